// File: rtl/myproject_sdiv_36s_14ns_22_seq.sv
// ---------------------------------------------------------------------------
// myproject_sdiv_36s_14ns_22_seq
//
// Sequential restoring divider: signed dividend / unsigned divisor.
// One quotient bit per cycle. The quotient is saturated to dout_WIDTH bits,
// and the remainder carries the sign of the dividend. Both sides use a
// valid/ready handshake, and only one operation is in flight at a time.
//
// Ports:
//   ap_clk     clock, rising edge
//   ap_rst_n   asynchronous active-low reset
//   in_valid   operands valid
//   in_ready   block can accept operands (IDLE only)
//   din0       signed dividend, din0_WIDTH bits
//   din1       unsigned divisor, din1_WIDTH bits
//   out_valid  result valid (DONE state)
//   out_ready  consumer accepts result
//   dout       signed quotient, truncated toward zero, saturated
//   rem        signed remainder, din1_WIDTH+1 bits, sign follows dividend
//   ovf        quotient was saturated
//   dbz        divisor was zero
// ---------------------------------------------------------------------------
module myproject_sdiv_36s_14ns_22_seq #(
  parameter int din0_WIDTH = 36,
  parameter int din1_WIDTH = 14,
  parameter int dout_WIDTH = 22
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [dout_WIDTH-1:0] dout,
  output logic [din1_WIDTH:0]   rem,
  output logic                  ovf,
  output logic                  dbz
);

  localparam int CW = $clog2(din0_WIDTH + 1);
  localparam int HW = din0_WIDTH - dout_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    SIGN,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0]         cnt;
  // Holds the dividend magnitude; quotient bits shift in from the bottom
  // while dividend bits shift out of the top.
  logic [din0_WIDTH-1:0] quo;
  logic [din1_WIDTH:0]   part;
  logic [din1_WIDTH-1:0] dvs;
  logic                  neg;

  logic                  accept;
  logic [din0_WIDTH-1:0] din0_abs;
  logic [din1_WIDTH:0]   shifted;
  logic [din1_WIDTH+1:0] diff;
  logic                  fits;

  logic [HW-1:0]         q_hi;
  logic [dout_WIDTH-2:0] q_lo;
  logic                  pos_ovf;
  logic                  neg_ovf;
  logic                  zero_div;
  logic [dout_WIDTH-1:0] q_neg;
  logic [dout_WIDTH-1:0] max_pos;
  logic [dout_WIDTH-1:0] min_neg;
  logic [dout_WIDTH-1:0] dout_nxt;
  logic [din1_WIDTH:0]   rem_nxt;
  logic                  ovf_nxt;

  // State register
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)          state_nxt = CALC;
      CALC:    if (cnt == CW'(1))   state_nxt = SIGN;
      SIGN:                         state_nxt = DONE;
      DONE:    if (out_ready)       state_nxt = IDLE;
      default:                      state_nxt = IDLE;
    endcase
  end

  // Handshake outputs; in_ready is forced low while reset is held
  always_comb begin
    in_ready  = (state == IDLE) && ap_rst_n;
    out_valid = (state == DONE);
  end

  assign accept = in_valid && in_ready;

  // Magnitude of the most negative dividend fits the unsigned register
  assign din0_abs = din0[din0_WIDTH-1] ? ('0 - din0) : din0;

  // One restoring step. The partial remainder is always below the divisor,
  // so its top bit is free to receive the shifted-in dividend bit.
  always_comb begin
    shifted = {part[din1_WIDTH-1:0], quo[din0_WIDTH-1]};
    diff    = {1'b0, shifted} - {2'b00, dvs};
    fits    = !diff[din1_WIDTH+1];
  end

  // Sign application and saturation
  always_comb begin
    max_pos  = {1'b0, {(dout_WIDTH-1){1'b1}}};
    min_neg  = {1'b1, {(dout_WIDTH-1){1'b0}}};
    zero_div = (dvs == '0);
    q_hi     = quo[din0_WIDTH-1:dout_WIDTH-1];
    q_lo     = quo[dout_WIDTH-2:0];
    q_neg    = '0 - quo[dout_WIDTH-1:0];
    pos_ovf  = |q_hi;
    // -2^(dout_WIDTH-1) itself is representable; anything larger is not
    neg_ovf  = (q_hi > HW'(1)) || ((q_hi == HW'(1)) && (|q_lo));

    dout_nxt = '0;
    rem_nxt  = '0;
    ovf_nxt  = 1'b0;
    if (zero_div) begin
      dout_nxt = neg ? min_neg : max_pos;
      rem_nxt  = '0;
      ovf_nxt  = 1'b1;
    end else if (neg) begin
      dout_nxt = neg_ovf ? min_neg : q_neg;
      rem_nxt  = '0 - part;
      ovf_nxt  = neg_ovf;
    end else begin
      dout_nxt = pos_ovf ? max_pos : quo[dout_WIDTH-1:0];
      rem_nxt  = part;
      ovf_nxt  = pos_ovf;
    end
  end

  // Datapath and result registers
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      cnt  <= '0;
      quo  <= '0;
      part <= '0;
      dvs  <= '0;
      neg  <= 1'b0;
      dout <= '0;
      rem  <= '0;
      ovf  <= 1'b0;
      dbz  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            quo  <= din0_abs;
            neg  <= din0[din0_WIDTH-1];
            dvs  <= din1;
            part <= '0;
            cnt  <= CW'(din0_WIDTH);
          end
        end
        CALC: begin
          part <= fits ? diff[din1_WIDTH:0] : shifted;
          quo  <= {quo[din0_WIDTH-2:0], fits};
          cnt  <= cnt - CW'(1);
        end
        SIGN: begin
          dout <= dout_nxt;
          rem  <= rem_nxt;
          ovf  <= ovf_nxt;
          dbz  <= zero_div;
        end
        default: ;
      endcase
    end
  end

endmodule
